// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the wait-stated data memory: FSM encoding and
// the value returned by a misaligned access.
package data_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [31:0] MISALIGN_RDATA = 32'h0;
    localparam int          CNT_W          = 4;

endpackage

// File: rtl/data_mem_resp_wait_counter.sv
// Down-counter that times the stall window of one memory access.
// tc flags the last BUSY cycle (count == 1).
module wait_counter
    import data_mem_resp_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/data_mem_resp.sv
// Single-port data memory with a fixed WAIT_CYCLES stall per access.
// The access itself happens on the edge that enters DONE.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        misalign,
    output state_t      state
);

    localparam int AW = $clog2(DEPTH);

    state_t        state_q, state_d;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          write_q, read_q;

    logic          request, cnt_load, cnt_dec, cnt_tc, enter_done;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_write, acc_read, acc_aligned;
    logic [AW-1:0] acc_idx;
    logic          unused_addr_bits;

    logic [31:0]   mem [DEPTH];

    // Upper address bits fold away: the array wraps modulo DEPTH*4 bytes.
    assign unused_addr_bits = ^Addr[31:AW+2];

    assign request = MemRead | MemWrite;
    assign state   = state_q;

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    stall    = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = (WAIT_CYCLES == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_tc) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_load) begin
                addr_q  <= Addr[AW+1:0];
                wdata_q <= WriteData;
                write_q <= MemWrite;
                read_q  <= MemRead;
            end
        end
    end

    wait_counter #(.W(CNT_W)) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (CNT_W'(WAIT_CYCLES - 1)),
        .dec        (cnt_dec),
        .tc         (cnt_tc)
    );

    // With a single wait cycle DONE is entered straight from IDLE, so the
    // access must use the live inputs rather than the not-yet-latched copies.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = Addr[AW+1:0];
            acc_wdata = WriteData;
            acc_write = MemWrite;
            acc_read  = MemRead;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_write = write_q;
            acc_read  = read_q;
        end
    end

    assign enter_done  = (state_d == DONE) && (state_q != DONE);
    assign acc_aligned = (acc_addr[1:0] == 2'b00);
    assign acc_idx     = acc_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (enter_done && acc_write && acc_aligned) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Non-blocking read of mem gives pre-write data when read and write coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadData <= '0;
            misalign <= 1'b0;
        end else if (enter_done) begin
            if (!acc_aligned) begin
                ReadData <= MISALIGN_RDATA;
                misalign <= 1'b1;
            end else if (acc_read) begin
                ReadData <= mem[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (2 and 1 wait cycles), directed
// scenarios plus randomized accesses checked against a word-array model.
module tb_data_mem_resp;
    import data_mem_resp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] addr0, wdata0, rdata0;
    logic        we0, re0, stall0, mis0;
    state_t      st0;
    logic [31:0] addr1, wdata1, rdata1;
    logic        we1, re1, stall1, mis1;
    state_t      st1;

    data_mem_resp #(.DEPTH(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .Addr(addr0), .WriteData(wdata0),
        .MemWrite(we0), .MemRead(re0), .ReadData(rdata0),
        .stall(stall0), .misalign(mis0), .state(st0)
    );

    data_mem_resp #(.DEPTH(256), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .Addr(addr1), .WriteData(wdata1),
        .MemWrite(we1), .MemRead(re1), .ReadData(rdata1),
        .stall(stall1), .misalign(mis1), .state(st1)
    );

    int tests = 0;
    int fails = 0;

    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];
    logic [32:0] e0, e1;

    logic [31:0] mem_model [2][256];
    logic [31:0] rd_model  [2];
    logic        mis_model [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word-addressed array, 8-bit index, misaligned access zeroes the read data.
    task automatic model_access(input int w, input logic [31:0] a, input logic [31:0] d,
                                input logic wr, input logic rd, output logic [32:0] e);
        int idx;
        idx = int'(a[9:2]);
        if (a[1:0] != 2'b00) begin
            mis_model[w] = 1'b1;
            rd_model[w]  = 32'h0;
        end else begin
            if (rd) rd_model[w] = mem_model[w][idx];
            if (wr) mem_model[w][idx] = d;
        end
        e = {mis_model[w], rd_model[w]};
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] d,
                         input logic wr, input logic rd);
        if (w == 0) begin
            addr0 = a; wdata0 = d; we0 = wr; re0 = rd;
        end else begin
            addr1 = a; wdata1 = d; we1 = wr; re1 = rd;
        end
    endtask

    task automatic access(input int w, input logic [31:0] a, input logic [31:0] d,
                          input logic wr, input logic rd);
        logic [32:0] e;
        int          n;
        logic        s;
        state_t      st;
        model_access(w, a, d, wr, rd, e);
        if (w == 0) exp0_q.push_back(e); else exp1_q.push_back(e);
        @(posedge clk); #1;
        drive(w, a, d, wr, rd);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s = (w == 0) ? stall0 : stall1;
            if (!s) break;
            n++;
        end
        check((w == 0) ? "u0_stall_cycles" : "u1_stall_cycles", n, (w == 0) ? 32'd2 : 32'd1);
        st = (w == 0) ? st0 : st1;
        check((w == 0) ? "u0_state_done" : "u1_state_done", 32'(st), 32'(DONE));
        // Request is still held through DONE; it must not start another access.
        @(posedge clk); #1;
        drive(w, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        st = (w == 0) ? st0 : st1;
        check((w == 0) ? "u0_state_idle" : "u1_state_idle", 32'(st), 32'(IDLE));
    endtask

    always @(negedge clk) begin
        if (!rst && st0 == DONE) begin
            if (exp0_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL u0_unexpected_done: got DONE expected no access");
            end else begin
                e0 = exp0_q.pop_front();
                check("u0_read_data", rdata0, e0[31:0]);
                check("u0_misalign", {31'b0, mis0}, {31'b0, e0[32]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && st1 == DONE) begin
            if (exp1_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL u1_unexpected_done: got DONE expected no access");
            end else begin
                e1 = exp1_q.pop_front();
                check("u1_read_data", rdata1, e1[31:0]);
                check("u1_misalign", {31'b0, mis1}, {31'b0, e1[32]});
            end
        end
    end

    initial begin
        #300000;
        tests++; fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [31:0] a, prior;
        logic        wr, rd;

        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int w = 0; w < 2; w++) begin
            rd_model[w]  = 32'h0;
            mis_model[w] = 1'b0;
        end
        #3;
        check("reset_u0_stall", {31'b0, stall0}, 32'h0);
        check("reset_u0_read_data", rdata0, 32'h0);
        check("reset_u0_misalign", {31'b0, mis0}, 32'h0);
        check("reset_u0_state", 32'(st0), 32'(IDLE));
        check("reset_u1_read_data", rdata1, 32'h0);
        check("reset_u1_state", 32'(st1), 32'(IDLE));
        #9;
        rst = 1'b0;

        // Single-wait instance: store/load at the top word, then combined read+write.
        access(1, 32'h3FC, 32'h12345678, 1'b1, 1'b0);
        access(1, 32'h3FC, 32'h0, 1'b0, 1'b1);
        access(1, 32'h3FC, 32'hCAFEF00D, 1'b1, 1'b1);
        access(1, 32'h3FC, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 256; i++) begin
            access(0, 32'(i * 4), $urandom, 1'b1, 1'b0);
        end

        access(0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        access(0, 32'h10, 32'h0, 1'b0, 1'b1);

        access(0, 32'h400, 32'hA5A5A5A5, 1'b1, 1'b0);
        access(0, 32'h0, 32'h0, 1'b0, 1'b1);

        access(0, 32'h4, 32'h5, 1'b1, 1'b0);
        access(0, 32'h4, 32'h9, 1'b1, 1'b1);
        access(0, 32'h4, 32'h0, 1'b0, 1'b1);

        access(0, 32'h22, 32'h77777777, 1'b1, 1'b0);
        check("misalign_set", {31'b0, mis0}, 32'h1);
        access(0, 32'h20, 32'h0, 1'b0, 1'b1);
        check("misalign_sticky", {31'b0, mis0}, 32'h1);

        // Reset in the BUSY cycle of a store: the store must be dropped.
        prior = mem_model[0][2];
        @(posedge clk); #1;
        drive(0, 32'h8, 32'h1, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_busy_stall_before", {31'b0, stall0}, 32'h1);
        @(posedge clk); #1;
        check("rst_busy_state_before", 32'(st0), 32'(BUSY));
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst_busy_stall_after", {31'b0, stall0}, 32'h0);
        check("rst_busy_state_after", 32'(st0), 32'(IDLE));
        check("rst_busy_read_data", rdata0, 32'h0);
        check("rst_busy_misalign", {31'b0, mis0}, 32'h0);
        #2;
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            rd_model[w]  = 32'h0;
            mis_model[w] = 1'b0;
        end
        access(0, 32'h8, 32'h0, 1'b0, 1'b1);
        check("rst_busy_prior_kept", mem_model[0][2], prior);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!wr && !rd) rd = 1'b1;
            access(0, a, $urandom, wr, rd);
        end

        repeat (3) @(posedge clk);
        check("u0_queue_drained", 32'(exp0_q.size()), 32'h0);
        check("u1_queue_drained", 32'(exp1_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
